// File: rtl/jtag_types_pkg.sv
// Shared JTAG instruction-register types and opcodes.
// Opcode constants are sized by the package default IR length.
package jtag_types_pkg;

    localparam int unsigned IR_WIDTH = 5;

    typedef logic [IR_WIDTH-1:0] instruction_t;

    localparam instruction_t BYPASS = '1;
    localparam instruction_t IDCODE = 5'b00001;
    localparam instruction_t SAMPLE = 5'b00010;
    localparam instruction_t EXTEST = 5'b00000;

    // Width needed to count 0..w inclusive.
    function automatic int unsigned cnt_width(int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/param_instruction_reg.sv
// JTAG instruction register: capture/shift stage plus update stage with
// length and opcode-support checking on every update.
module param_instruction_reg #(
    parameter int unsigned             IR_WIDTH    = 5,
    parameter logic [IR_WIDTH-1:0]     RESET_INSTR = IR_WIDTH'(jtag_types_pkg::IDCODE),
    parameter logic [2**IR_WIDTH-1:0]  SUPPORTED   = '1
) (
    input  logic                TCK,
    input  logic                nTRST,
    input  logic                TDI,
    input  logic                ir_capture,
    input  logic                ir_shift,
    input  logic                ir_update,
    input  logic                tlr_reset,
    input  logic [IR_WIDTH-3:0] capture_status,
    output logic                TDO,
    output logic [IR_WIDTH-1:0] parallel_out,
    output logic                instr_valid,
    output logic                update_pulse,
    output logic                len_error
);
    import jtag_types_pkg::*;

    localparam int unsigned CntW = cnt_width(IR_WIDTH);
    localparam logic [CntW-1:0] FullCnt = CntW'(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] Bypass = '1;

    logic [IR_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CntW-1:0]     shift_cnt_q, shift_cnt_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                len_err_q, len_err_d;
    logic                pulse_q, pulse_d;

    always_comb begin
        shift_reg_d = shift_reg_q;
        shift_cnt_d = shift_cnt_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        len_err_d   = len_err_q;
        pulse_d     = 1'b0;

        // Strobes are mutually exclusive by priority; lower ones are dropped.
        if (ir_update) begin
            pulse_d = 1'b1;
            if (shift_cnt_q < FullCnt) begin
                instr_d   = Bypass;
                valid_d   = 1'b0;
                len_err_d = 1'b1;
            end else if (!SUPPORTED[shift_reg_q]) begin
                instr_d = Bypass;
                valid_d = 1'b0;
            end else begin
                instr_d   = shift_reg_q;
                valid_d   = 1'b1;
                len_err_d = 1'b0;
            end
        end else if (ir_capture) begin
            shift_reg_d = {capture_status, 2'b01};
            shift_cnt_d = '0;
        end else if (ir_shift) begin
            shift_reg_d = {TDI, shift_reg_q[IR_WIDTH-1:1]};
            // Saturate so over-long shifts still count as complete.
            if (shift_cnt_q != FullCnt) begin
                shift_cnt_d = shift_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (!nTRST || tlr_reset) begin
            shift_reg_q <= '0;
            shift_cnt_q <= '0;
            instr_q     <= RESET_INSTR;
            valid_q     <= 1'b1;
            len_err_q   <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            shift_reg_q <= shift_reg_d;
            shift_cnt_q <= shift_cnt_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            len_err_q   <= len_err_d;
            pulse_q     <= pulse_d;
        end
    end

    assign TDO          = shift_reg_q[0];
    assign parallel_out = instr_q;
    assign instr_valid  = valid_q;
    assign len_error    = len_err_q;
    assign update_pulse = pulse_q;

endmodule

// File: tb/tb_param_instruction_reg.sv
// Directed vector bench for param_instruction_reg (IR_WIDTH=5, opcodes 0,1,2,31 supported).
module tb_param_instruction_reg;

    logic       TCK = 1'b0;
    logic       nTRST = 1'b1;
    logic       TDI = 1'b0;
    logic       ir_capture = 1'b0;
    logic       ir_shift = 1'b0;
    logic       ir_update = 1'b0;
    logic       tlr_reset = 1'b0;
    logic [2:0] capture_status = 3'b000;
    logic       TDO;
    logic [4:0] parallel_out;
    logic       instr_valid;
    logic       update_pulse;
    logic       len_error;

    int total = 0;
    int bad = 0;

    param_instruction_reg #(
        .IR_WIDTH   (5),
        .RESET_INSTR(5'b00001),
        .SUPPORTED  (32'h8000_0007)
    ) dut (
        .TCK           (TCK),
        .nTRST         (nTRST),
        .TDI           (TDI),
        .ir_capture    (ir_capture),
        .ir_shift      (ir_shift),
        .ir_update     (ir_update),
        .tlr_reset     (tlr_reset),
        .capture_status(capture_status),
        .TDO           (TDO),
        .parallel_out  (parallel_out),
        .instr_valid   (instr_valid),
        .update_pulse  (update_pulse),
        .len_error     (len_error)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic       rst_n;
        logic       tlr;
        logic       upd;
        logic       cap;
        logic       sh;
        logic       tdi;
        logic [2:0] st;
        logic       e_tdo;
        logic [4:0] e_po;
        logic       e_valid;
        logic       e_len;
        logic       e_pulse;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic tlr, logic upd, logic cap, logic sh,
                                logic tdi, logic [2:0] st, logic e_tdo, logic [4:0] e_po,
                                logic e_valid, logic e_len, logic e_pulse);
        vec_t v;
        v.rst_n = rst_n; v.tlr = tlr; v.upd = upd; v.cap = cap; v.sh = sh;
        v.tdi = tdi; v.st = st; v.e_tdo = e_tdo; v.e_po = e_po;
        v.e_valid = e_valid; v.e_len = e_len; v.e_pulse = e_pulse;
        return v;
    endfunction

    task automatic drive(logic rst_n, logic tlr, logic upd, logic cap, logic sh,
                         logic tdi, logic [2:0] st);
        @(negedge TCK);
        nTRST = rst_n; tlr_reset = tlr; ir_update = upd; ir_capture = cap;
        ir_shift = sh; TDI = tdi; capture_status = st;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        int highs;
        logic [4:0] act;
        //                rst tlr upd cap sh tdi st       tdo po        v  len pulse
        // Reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        // Capture 101 then shift zeros: TDO walks 1,0,1,0,1
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b101,   1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        // Load SAMPLE (00010)
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   0, 5'b00010, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b000,   0, 5'b00010, 1, 0, 0));
        // Short shift: 3 bits then update
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b00010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b00010, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   0, 5'b11111, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b000,   0, 5'b11111, 0, 1, 0));
        // Unsupported 00111: bypass, len_error kept
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   0, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000,   1, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   1, 5'b11111, 0, 1, 1));
        // EXTEST 00000: valid, len_error cleared
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b11111, 0, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b000, 0, 5'b11111, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   0, 5'b00000, 1, 0, 1));
        // Over-long shift of seven ones keeps last five: 11111 supported
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   1, 5'b11111, 1, 0, 1));
        // Reset mid-shift, then update without capture flags length error
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'b000,   1, 5'b11111, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000,   0, 5'b11111, 0, 1, 1));
        // tlr_reset beats ir_update; pulse stays low
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b000,   0, 5'b00001, 1, 0, 0));
        // Update beats capture and shift
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 3'b111,   0, 5'b11111, 0, 1, 1));
        // Capture beats shift
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 3'b111,   1, 5'b11111, 0, 1, 0));
        // Idle holds
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3'b000,   1, 5'b11111, 0, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].tlr, vecs[i].upd, vecs[i].cap, vecs[i].sh,
                  vecs[i].tdi, vecs[i].st);
            total++;
            if (TDO !== vecs[i].e_tdo || parallel_out !== vecs[i].e_po ||
                instr_valid !== vecs[i].e_valid || len_error !== vecs[i].e_len ||
                update_pulse !== vecs[i].e_pulse) begin
                bad++;
                $display("FAIL vec%0d: got tdo=%b po=%b valid=%b len=%b pulse=%b, want tdo=%b po=%b valid=%b len=%b pulse=%b",
                         i, TDO, parallel_out, instr_valid, len_error, update_pulse,
                         vecs[i].e_tdo, vecs[i].e_po, vecs[i].e_valid, vecs[i].e_len,
                         vecs[i].e_pulse);
            end
        end

        // parallel_out must stay put through capture and shifting
        drive(0, 0, 0, 0, 0, 0, 3'b000);
        drive(1, 0, 0, 1, 0, 0, 3'b110);
        for (int i = 0; i < 6; i++) begin
            act = parallel_out;
            total++;
            if (act !== 5'b00001) begin
                bad++;
                $display("FAIL po_hold%0d: got %b want 00001", i, act);
            end
            drive(1, 0, 0, 0, 1, 1, 3'b000);
        end

        // update_pulse is high for exactly one cycle after an update
        drive(1, 0, 1, 0, 0, 0, 3'b000);
        total++;
        if (update_pulse !== 1'b1) begin
            bad++;
            $display("FAIL pulse_first: got %b want 1", update_pulse);
        end
        highs = (update_pulse === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 3'b000);
            if (update_pulse === 1'b1) highs++;
        end
        total++;
        if (highs != 1) begin
            bad++;
            $display("FAIL pulse_width: got %0d high cycles want 1", highs);
        end
        total++;
        if (parallel_out !== 5'b11111 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL pulse_load: got po=%b valid=%b want po=11111 valid=1",
                     parallel_out, instr_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
